// File: rtl/wb_bram_ctrl.sv
// rtl/wb_bram_ctrl.sv - Wishbone slave to single-port BRAM bridge with programmable wait states
module wb_bram_ctrl #(
    parameter int          DELAYS = 10,
    parameter int          ADDR_W = 7,
    parameter logic [7:0]  BASE   = 8'h38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    // Wait-state count loaded on acceptance; DELAYS is limited to 0..255.
    localparam logic [7:0] DELAY_LOAD = 8'(DELAYS);

    state_t              state;
    state_t              next_state;
    logic [7:0]          cnt;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         dat_q;
    logic                hit;
    logic                bus_held;

    // Address bits outside the decoded window and the byte lane are don't-care.
    logic                unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    assign bus_held = wbs_cyc_i & wbs_stb_i;
    assign hit      = bus_held & (wbs_adr_i[31:24] == BASE);

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: wait states may be aborted by the master, access and ack are one cycle each.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    next_state = (DELAYS > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!bus_held) begin
                    next_state = IDLE;
                end else if (cnt == 8'd1) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: next_state = ACK;
            ACK:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture and wait counter; bus fields are frozen at acceptance.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt    <= 8'd0;
            we_q   <= 1'b0;
            sel_q  <= 4'b0;
            addr_q <= '0;
            dat_q  <= 32'h0;
        end else begin
            if (state == IDLE && hit) begin
                cnt    <= DELAY_LOAD;
                we_q   <= wbs_we_i;
                sel_q  <= wbs_sel_i;
                addr_q <= wbs_adr_i[ADDR_W+1:2];
                dat_q  <= wbs_dat_i;
            end else if (state == WAIT) begin
                if (!bus_held) begin
                    cnt <= 8'd0;
                end else if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

    // Output decode: BRAM strobes only in ACCESS, ack and read data only in ACK.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 4'b0;
        wbs_ack_o = 1'b0;
        wbs_dat_o = 32'h0;
        bram_addr = addr_q;
        bram_di   = dat_q;
        if (state == ACCESS) begin
            bram_en = 1'b1;
            bram_we = we_q ? sel_q : 4'b0;
        end
        if (state == ACK) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = we_q ? 32'h0 : bram_do;
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb/tb_wb_bram_ctrl.sv - directed scoreboard bench for wb_bram_ctrl (DELAYS=10 and DELAYS=0)
module tb_wb_bram_ctrl;

    localparam logic [7:0] BASE = 8'h38;
    localparam int         AW   = 7;

    typedef struct {
        logic          rd;
        logic [3:0]    bwe;
        logic [AW-1:0] addr;
        logic [31:0]   di;
        logic [31:0]   rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc   [2];
    logic          stb   [2];
    logic          we    [2];
    logic [3:0]    sel   [2];
    logic [31:0]   adr   [2];
    logic [31:0]   dat   [2];
    logic          ack   [2];
    logic [31:0]   dat_o [2];
    logic          en    [2];
    logic [3:0]    bwe   [2];
    logic [AW-1:0] baddr [2];
    logic [31:0]   bdi   [2];

    logic [31:0]   model [2][1<<AW];
    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    // Instance 0 runs DELAYS=10, instance 1 runs DELAYS=0; each has its own BRAM.
    for (genvar g = 0; g < 2; g++) begin : u
        logic [31:0] mem [0:(1<<AW)-1];
        logic [31:0] rd;

        wb_bram_ctrl #(.DELAYS(g == 0 ? 10 : 0), .ADDR_W(AW), .BASE(BASE)) dut (
            .wb_clk_i  (clk),
            .wb_rst_i  (rst),
            .wbs_cyc_i (cyc[g]),
            .wbs_stb_i (stb[g]),
            .wbs_we_i  (we[g]),
            .wbs_sel_i (sel[g]),
            .wbs_adr_i (adr[g]),
            .wbs_dat_i (dat[g]),
            .wbs_ack_o (ack[g]),
            .wbs_dat_o (dat_o[g]),
            .bram_en   (en[g]),
            .bram_we   (bwe[g]),
            .bram_addr (baddr[g]),
            .bram_di   (bdi[g]),
            .bram_do   (rd)
        );

        always_ff @(posedge clk) begin
            if (en[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (bwe[g][b]) mem[baddr[g]][8*b +: 8] <= bdi[g][8*b +: 8];
                end
                rd <= mem[baddr[g]];
            end else begin
                rd <= 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] v, input int extra, input bit keep);
        exp_t          e;
        exp_t          f;
        int            dl;
        int            en_at;
        int            ack_at;
        logic [AW-1:0] wa;
        dl = (d == 0) ? 10 : 0;
        wa = a[AW+1:2];
        e.rd    = ~w;
        e.bwe   = w ? s : 4'h0;
        e.addr  = wa;
        e.di    = v;
        e.rdata = model[d][wa];
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[d][wa][8*b +: 8] = v[8*b +: 8];
            end
        end
        sb.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat[d] = v;
        en_at  = -1;
        ack_at = -1;
        for (int k = 1; k <= dl + extra + 8 && ack_at < 0; k++) begin
            cycle();
            if (k == 1 + extra) begin
                we[d]  = ~w;
                sel[d] = ~s;
                adr[d] = {BASE, 24'($urandom())};
                dat[d] = $urandom();
            end
            if (en[d] && en_at < 0) begin
                en_at = k;
                f = sb[0];
                chk("bram_we", 32'(bwe[d]), 32'(f.bwe));
                chk("bram_addr", 32'(baddr[d]), 32'(f.addr));
                chk("bram_di", bdi[d], f.di);
            end
            if (ack[d]) begin
                ack_at = k;
                f = sb.pop_front();
                if (f.rd) chk("read_data", dat_o[d], f.rdata);
                else      chk("write_dat_o", dat_o[d], 32'h0);
            end
        end
        chk("en_cycle", en_at, dl + 1 + extra);
        chk("ack_cycle", ack_at, dl + 2 + extra);
        if (ack_at < 0 && sb.size() > 0) void'(sb.pop_front());
        if (!keep) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
            cycle();
            chk("dat_after_ack", dat_o[d], 32'h0);
            chk("ack_after_ack", 32'(ack[d]), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; adr[d] = 32'h0; dat[d] = 32'h0;
            for (int i = 0; i < (1 << AW); i++) model[d][i] = 32'h0;
        end
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'h0);
            chk("rst_dat_o", dat_o[d], 32'h0);
            chk("rst_en", 32'(en[d]), 32'h0);
            chk("rst_we", 32'(bwe[d]), 32'h0);
            chk("rst_addr", 32'(baddr[d]), 32'h0);
            chk("rst_di", bdi[d], 32'h0);
        end
        rst = 1'b0;
        cycle();

        // DELAYS=10: full write, read back, partial write, zero-select write.
        xfer(0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, 1'b0);
        xfer(0, 1'b1, 4'b0010, 32'h3800_0010, 32'h0000_AB00, 0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, 1'b0);
        chk("partial_model", model[0][4], 32'hDEAD_ABEF);
        xfer(0, 1'b1, 4'b0000, 32'h3800_0010, 32'hFFFF_FFFF, 0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, 1'b0);

        // Address outside the window is ignored.
        viol = 0;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        adr[0] = 32'h3000_0000; dat[0] = 32'h5555_AAAA;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (en[0] || ack[0]) viol++;
        end
        chk("miss_activity", viol, 0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cycle();

        // Master drops cyc in the fifth wait cycle.
        viol = 0;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h3800_0010;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (en[0] || ack[0]) viol++;
        end
        cyc[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (en[0] || ack[0]) viol++;
        end
        chk("abort_activity", viol, 0);
        stb[0] = 1'b0;
        cycle();

        // Reset asserted during wait states of a write.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        adr[0] = 32'h3800_0020; dat[0] = 32'h1234_5678;
        repeat (3) cycle();
        chk("latched_addr", 32'(baddr[0]), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack[0]), 32'h0);
        chk("midrst_en", 32'(en[0]), 32'h0);
        chk("midrst_addr", 32'(baddr[0]), 32'h0);
        chk("midrst_di", bdi[0], 32'h0);
        chk("midrst_dat_o", dat_o[0], 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cycle();
        rst = 1'b0;
        viol = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (en[0] || ack[0]) viol++;
        end
        chk("postrst_activity", viol, 0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 0, 1'b0);
        xfer(0, 1'b0, 4'hF, 32'h3800_0020, 32'h0, 0, 1'b0);

        // DELAYS=0: single accesses then back-to-back reads.
        xfer(1, 1'b1, 4'hF, 32'h3800_0040, 32'hCAFE_F00D, 0, 1'b0);
        xfer(1, 1'b1, 4'hF, 32'h3800_0044, 32'h0123_4567, 0, 1'b0);
        xfer(1, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 0, 1'b1);
        xfer(1, 1'b0, 4'hF, 32'h3800_0044, 32'h0, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = {BASE, 17'h0, 5'(i), 2'b00};
            xfer(1, 1'b1, 4'($urandom_range(1, 15)), a, $urandom(), 0, 1'b0);
            xfer(1, 1'b0, 4'hF, a, 32'h0, 0, 1'b0);
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_bram_ctrl.md
WB_BRAM_CTRL -- requirements
Module: wb_bram_ctrl

Parameters
REQ-001 SHALL have parameter DELAYS, default 10, meaning wait-state cycles inserted before each BRAM access (legal 0..255).
REQ-002 SHALL have parameter ADDR_W, default 7, meaning BRAM word-address width.
REQ-003 SHALL have parameter BASE, default 8'h38, meaning required value of wbs_adr_i[31:24] for a hit.

Interface
REQ-004 SHALL have wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have wbs_cyc_i  input  1  Wishbone cycle.
REQ-007 SHALL have wbs_stb_i  input  1  Wishbone strobe.
REQ-008 SHALL have wbs_we_i  input  1  write enable (1 = write).
REQ-009 SHALL have wbs_sel_i  input  4  byte selects.
REQ-010 SHALL have wbs_adr_i  input  32  byte address.
REQ-011 SHALL have wbs_dat_i  input  32  write data.
REQ-012 SHALL have wbs_ack_o  output  1  transfer acknowledge.
REQ-013 SHALL have wbs_dat_o  output  32  read data.
REQ-014 SHALL have bram_en  output  1  BRAM port enable.
REQ-015 SHALL have bram_we  output  4  BRAM per-byte write enables.
REQ-016 SHALL have bram_addr  output  ADDR_W  BRAM word address.
REQ-017 SHALL have bram_di  output  32  BRAM write data.
REQ-018 SHALL have bram_do  input  32  BRAM read data; registered, valid one cycle after the enabled edge, 0 in any cycle following an edge with bram_en=0.

Function
REQ-019 SHALL detect a hit when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE); non-hits SHALL be ignored (no ack, no BRAM activity).
REQ-020 SHALL implement FSM states IDLE, WAIT, ACCESS, ACK.
REQ-021 IDLE: on hit, latch we, sel, word address wbs_adr_i[ADDR_W+1:2], data; load counter with DELAYS; go WAIT if DELAYS>0, else ACCESS.
REQ-022 WAIT: decrement counter each cycle; go ACCESS in the cycle the counter reads 1 (exactly DELAYS cycles in WAIT).
REQ-023 WAIT: if wbs_cyc_i or wbs_stb_i is low, abort to IDLE with no BRAM access and no ack.
REQ-024 ACCESS (one cycle): bram_en=1; bram_we = latched we ? latched sel : 4'b0; bram_addr and bram_di from latched values; next state ACK unconditionally.
REQ-025 ACK (one cycle): wbs_ack_o=1; next state IDLE.
REQ-026 wbs_dat_o SHALL equal bram_do in ACK of a read, else 32'h0.
REQ-027 bram_en and bram_we SHALL be 0 and wbs_ack_o 0 in every state other than ACCESS / ACK respectively.
REQ-028 Latency: hit sampled at edge N -> bram_en high in cycle N+DELAYS+1, wbs_ack_o high in cycle N+DELAYS+2.
REQ-029 Changes on wbs_adr_i/dat_i/sel_i/we_i after acceptance SHALL NOT affect the access in progress.
REQ-030 A hit present in the first IDLE cycle after ACK SHALL be accepted as a new transfer (back-to-back allowed).
REQ-031 Write with wbs_sel_i=4'b0000 SHALL still run the full sequence and ack, with bram_we=0.

Reset
REQ-032 On wb_rst_i high, asynchronously: state IDLE, counter 0, latched fields 0, wbs_ack_o=0, wbs_dat_o=0, bram_en=0, bram_we=0, bram_addr=0, bram_di=0.
REQ-033 Reset asserted mid-transfer SHALL abandon it with no ack; first hit after release SHALL be handled normally.

Verification
REQ-034 DELAYS=10: write adr 0x3800_0010, dat 0xDEAD_BEEF, sel 4'hF -> bram_en=1, bram_we=4'hF, bram_addr=4 at cycle N+11; ack at N+12.
REQ-035 Read adr 0x3800_0010 after REQ-034 -> ack at N+12 with wbs_dat_o=0xDEAD_BEEF; wbs_dat_o=0 the cycle after.
REQ-036 Write sel 4'b0010, dat 0x0000_AB00 to word 4, then read -> 0xDEAD_ABEF.
REQ-037 Access adr 0x3000_0000 -> no ack, bram_en stays 0 for 20 cycles.
REQ-038 Drop wbs_cyc_i in WAIT cycle 5 -> no bram_en, no ack; assert wb_rst_i during WAIT of next transfer -> outputs 0 immediately, next read acks normally.
REQ-039 DELAYS=0: read -> bram_en at N+1, ack at N+2; two back-to-back reads ack at N+2 and N+5.
